control_unit: RTL and testbench

Multi-cycle Moore sequencer that drives every control input of the processor datapath. It steps each instruction through fetch and a per-opcode execute microsequence of one-hot control strobes. It consumes the decoded 5-bit opcode and the branch condition flag, and loads nothing itself.

---
 rtl/control_unit.sv | 145 ++++++++++++++
 tb/tb_control_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// control_unit: multi-cycle Moore sequencer driving every datapath control strobe
// Clock/clear: rising-edge clock, async active-low reset; operation: opcode from IR[31:27];
// CON_FF: branch condition; Stop: halt at next instruction boundary; Run: sequencing active;
// remaining outputs: one-hot register, ALU, memory, branch and port strobes.
module control_unit (
  input  logic       Clock,
  input  logic       clear,
  input  logic [4:0] operation,
  input  logic       CON_FF,
  input  logic       Stop,
  output logic       Run,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       r_in,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic       PCout,
  output logic       PCin,
  output logic       IncPC,
  output logic       MARin,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Zin_low,
  output logic       Zin_high,
  output logic       Zlowout,
  output logic       Zhighout,
  output logic       HIin,
  output logic       HIout,
  output logic       LOin,
  output logic       LOout,
  output logic       Read,
  output logic       Write,
  output logic       ConIn,
  output logic       R15in,
  output logic       In_Portout,
  output logic       outPortenable,
  output logic       inPortenable
);
  typedef enum logic [3:0] {RESET, T0, T1, T2, T3, E0, E1, E2, E3, E4, E5, HALT} state_t;
  state_t     state;
  state_t     boundary;
  logic [4:0] op;
  logic       alu_r, alu_i, neg_not, mul_div, is_ld, is_ldi, is_st, is_brx;
  logic       is_jr, is_jal, is_in, is_out, is_mfhi, is_mflo;
  // final execute step of each microsequence; the step after it is an instruction boundary
  function automatic state_t last_step(input logic [4:0] o);
    return o == 5'd0 ? E5 : o == 5'd2 ? E4 : o inside {5'd15, 5'd16, 5'd19} ? E3 :
           o inside {[5'd1:5'd14]} ? E2 : o inside {5'd17, 5'd18, 5'd21} ? E1 : E0;
  endfunction
  // nop plus the unassigned 111xx codes
  function automatic logic is_nop(input logic [4:0] o);
    return o == 5'd26 || o[4:2] == 3'b111;
  endfunction
  assign alu_r   = op inside {[5'd3:5'd11]};
  assign alu_i   = op inside {[5'd12:5'd14]};
  assign neg_not = op inside {5'd17, 5'd18};
  assign mul_div = op inside {5'd15, 5'd16};
  assign is_ld   = op == 5'd0;
  assign is_ldi  = op == 5'd1;
  assign is_st   = op == 5'd2;
  assign is_brx  = op == 5'd19;
  assign is_jr   = op == 5'd20;
  assign is_jal  = op == 5'd21;
  assign is_in   = op == 5'd22;
  assign is_out  = op == 5'd23;
  assign is_mfhi = op == 5'd24;
  assign is_mflo = op == 5'd25;
  // Stop only takes effect where the sequencer would otherwise enter T0
  assign boundary = Stop ? HALT : T0;
  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state <= RESET;
      op    <= '0;
    end else begin
      case (state)
        RESET: state <= boundary;
        T0: state <= T1;
        T1: state <= T2;
        T2: state <= T3;
        T3: begin
          op    <= operation;
          state <= operation == 5'd27 ? HALT : is_nop(operation) ? boundary : E0;
        end
        E0, E1, E2, E3, E4, E5: state <= state == last_step(op) ? boundary : state_t'(state + 4'd1);
        default: state <= HALT;
      endcase
    end
  end
  always_comb begin
    {Gra, Grb, Grc, r_in, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin} = '0;
    {Zin_low, Zin_high, Zlowout, Zhighout, HIin, HIout, LOin, LOout} = '0;
    {Read, Write, ConIn, R15in, In_Portout, outPortenable} = '0;
    Run          = state != RESET && state != HALT;
    inPortenable = state != RESET;
    case (state)
      T0: {PCout, MARin, IncPC, Zin_low} = '1;
      T1: {Zlowout, PCin, Read} = '1;
      T2: {Read, MDRin} = '1;
      T3: {MDRout, IRin} = '1;
      E0: begin
        if (alu_r || alu_i) {Grb, Rout, Yin} = '1;
        else if (neg_not) {Grb, Rout, Zin_low} = '1;
        else if (mul_div) {Gra, Rout, Yin} = '1;
        else if (is_ld || is_ldi || is_st) {Grb, BAout, Yin} = '1;
        else if (is_brx) {Gra, Rout, ConIn} = '1;
        else if (is_jr) {Gra, Rout, PCin} = '1;
        else if (is_jal) {PCout, R15in} = '1;
        else if (is_in) {In_Portout, Gra, r_in} = '1;
        else if (is_out) {Gra, Rout, outPortenable} = '1;
        else if (is_mfhi) {HIout, Gra, r_in} = '1;
        else if (is_mflo) {LOout, Gra, r_in} = '1;
      end
      E1: begin
        if (alu_r) {Grc, Rout, Zin_low} = '1;
        else if (alu_i || is_ld || is_ldi || is_st) {Cout, Zin_low} = '1;
        else if (neg_not) {Zlowout, Gra, r_in} = '1;
        else if (mul_div) {Grb, Rout, Zin_low, Zin_high} = '1;
        else if (is_brx) {PCout, Yin} = '1;
        else if (is_jal) {Gra, Rout, PCin} = '1;
      end
      E2: begin
        if (alu_r || alu_i || is_ldi) {Zlowout, Gra, r_in} = '1;
        else if (mul_div) {Zlowout, LOin} = '1;
        else if (is_ld || is_st) {Zlowout, MARin} = '1;
        else if (is_brx) {Cout, Zin_low} = '1;
      end
      E3: begin
        if (mul_div) {Zhighout, HIin} = '1;
        else if (is_ld) Read = 1'b1;
        else if (is_st) {Gra, Rout, MDRin} = '1;
        else if (is_brx) {Zlowout, PCin} = {1'b1, CON_FF};
      end
      E4: begin
        if (is_ld) {Read, MDRin} = '1;
        else if (is_st) Write = 1'b1;
      end
      E5: if (is_ld) {MDRout, Gra, r_in} = '1;
      default: ;
    endcase
  end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scoreboard bench comparing every cycle's strobes against microsequence tables
module tb_control_unit;
  logic Clock, clear, CON_FF, Stop;
  logic [4:0] operation;
  logic Run, Gra, Grb, Grc, r_in, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout, IRin, Yin;
  logic Zin_low, Zin_high, Zlowout, Zhighout, HIin, HIout, LOin, LOout;
  logic Read, Write, ConIn, R15in, In_Portout, outPortenable, inPortenable;
  logic [30:0] obs;
  localparam logic [30:0] RUN = 31'd1 << 30, GRA = 31'd1 << 29, GRB = 31'd1 << 28, GRC = 31'd1 << 27;
  localparam logic [30:0] RIN = 31'd1 << 26, ROUT = 31'd1 << 25, BAOUT = 31'd1 << 24, COUT = 31'd1 << 23;
  localparam logic [30:0] PCOUT = 31'd1 << 22, PCIN = 31'd1 << 21, INCPC = 31'd1 << 20, MARIN = 31'd1 << 19;
  localparam logic [30:0] MDRIN = 31'd1 << 18, MDROUT = 31'd1 << 17, IRIN = 31'd1 << 16, YIN = 31'd1 << 15;
  localparam logic [30:0] ZINL = 31'd1 << 14, ZINH = 31'd1 << 13, ZLO = 31'd1 << 12, ZHO = 31'd1 << 11;
  localparam logic [30:0] HIIN = 31'd1 << 10, HIOUT = 31'd1 << 9, LOIN = 31'd1 << 8, LOOUT = 31'd1 << 7;
  localparam logic [30:0] READ = 31'd1 << 6, WRITE = 31'd1 << 5, CONIN = 31'd1 << 4, R15IN = 31'd1 << 3;
  localparam logic [30:0] INPO = 31'd1 << 2, OUTPE = 31'd1 << 1, INPE = 31'd1;
  logic [30:0] exp_q[$];
  string       tag_q[$];
  logic [30:0] tr[$];
  int n_chk = 0;
  int n_fail = 0;
  control_unit dut (
    .Clock(Clock), .clear(clear), .operation(operation), .CON_FF(CON_FF), .Stop(Stop), .Run(Run),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .r_in(r_in), .Rout(Rout), .BAout(BAout), .Cout(Cout),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin_low(Zin_low), .Zin_high(Zin_high), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout), .Read(Read),
    .Write(Write), .ConIn(ConIn), .R15in(R15in), .In_Portout(In_Portout),
    .outPortenable(outPortenable), .inPortenable(inPortenable)
  );
  assign obs = {Run, Gra, Grb, Grc, r_in, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin, MDRout,
                IRin, Yin, Zin_low, Zin_high, Zlowout, Zhighout, HIin, HIout, LOin, LOout, Read, Write,
                ConIn, R15in, In_Portout, outPortenable, inPortenable};
  initial begin
    Clock = 0;
    forever #5 Clock = ~Clock;
  end
  initial begin
    #500000;
    n_chk++;
    n_fail++;
    $display("FAIL timeout: test did not complete, %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial forever @(negedge Clock) begin
    if (exp_q.size() > 0) begin
      logic [30:0] e;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      n_chk++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL %s: strobes=%h expected=%h", t, obs, e);
      end
    end
  end
  task automatic build(input logic [4:0] o, input logic c);
    tr.delete();
    tr.push_back(PCOUT | MARIN | INCPC | ZINL);
    tr.push_back(ZLO | PCIN | READ);
    tr.push_back(READ | MDRIN);
    tr.push_back(MDROUT | IRIN);
    if (o >= 5'd3 && o <= 5'd11) begin
      tr.push_back(GRB | ROUT | YIN); tr.push_back(GRC | ROUT | ZINL); tr.push_back(ZLO | GRA | RIN);
    end else if (o >= 5'd12 && o <= 5'd14) begin
      tr.push_back(GRB | ROUT | YIN); tr.push_back(COUT | ZINL); tr.push_back(ZLO | GRA | RIN);
    end else if (o == 5'd17 || o == 5'd18) begin
      tr.push_back(GRB | ROUT | ZINL); tr.push_back(ZLO | GRA | RIN);
    end else if (o == 5'd15 || o == 5'd16) begin
      tr.push_back(GRA | ROUT | YIN); tr.push_back(GRB | ROUT | ZINL | ZINH);
      tr.push_back(ZLO | LOIN); tr.push_back(ZHO | HIIN);
    end else if (o == 5'd0) begin
      tr.push_back(GRB | BAOUT | YIN); tr.push_back(COUT | ZINL); tr.push_back(ZLO | MARIN);
      tr.push_back(READ); tr.push_back(READ | MDRIN); tr.push_back(MDROUT | GRA | RIN);
    end else if (o == 5'd1) begin
      tr.push_back(GRB | BAOUT | YIN); tr.push_back(COUT | ZINL); tr.push_back(ZLO | GRA | RIN);
    end else if (o == 5'd2) begin
      tr.push_back(GRB | BAOUT | YIN); tr.push_back(COUT | ZINL); tr.push_back(ZLO | MARIN);
      tr.push_back(GRA | ROUT | MDRIN); tr.push_back(WRITE);
    end else if (o == 5'd19) begin
      tr.push_back(GRA | ROUT | CONIN); tr.push_back(PCOUT | YIN); tr.push_back(COUT | ZINL);
      tr.push_back(c ? (ZLO | PCIN) : ZLO);
    end else if (o == 5'd20) tr.push_back(GRA | ROUT | PCIN);
    else if (o == 5'd21) begin
      tr.push_back(PCOUT | R15IN); tr.push_back(GRA | ROUT | PCIN);
    end else if (o == 5'd22) tr.push_back(INPO | GRA | RIN);
    else if (o == 5'd23) tr.push_back(GRA | ROUT | OUTPE);
    else if (o == 5'd24) tr.push_back(HIOUT | GRA | RIN);
    else if (o == 5'd25) tr.push_back(LOOUT | GRA | RIN);
  endtask
  task automatic run_instr(input logic [4:0] o, input logic c, input logic stp, input int cut);
    int n;
    build(o, c);
    n = (cut >= 0 && cut < tr.size()) ? cut : tr.size();
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(tr[i] | RUN | INPE);
      tag_q.push_back($sformatf("op%0d_cyc%0d", o, i));
    end
    for (int i = 0; i < n; i++) begin
      @(posedge Clock);
      #1;
      operation = (i == 3) ? o : 5'($urandom);
      CON_FF    = (i == 7) ? c : 1'($urandom);
      Stop      = (i == n - 1) ? stp : 1'($urandom);
    end
  endtask
  task automatic do_reset(input int k);
    @(posedge Clock);
    #1;
    clear = 0;
    Stop  = 0;
    #1;
    n_chk++;
    if (obs !== '0) begin
      n_fail++;
      $display("FAIL async_reset: strobes=%h expected=0", obs);
    end
    for (int i = 0; i < k; i++) begin
      exp_q.push_back('0);
      tag_q.push_back($sformatf("reset_cyc%0d", i));
    end
    repeat (k - 1) begin
      @(posedge Clock);
      #1;
    end
    clear = 1;
  endtask
  task automatic halt_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(INPE);
      tag_q.push_back($sformatf("halt_cyc%0d", i));
    end
    repeat (2) begin
      @(posedge Clock);
      #1;
      Stop = 1'($urandom);
      operation = 5'($urandom);
    end
    do_reset(2);
  endtask
  initial begin
    logic [4:0] o;
    logic s;
    clear = 0;
    Stop = 0;
    operation = '0;
    CON_FF = 0;
    do_reset(3);
    run_instr(5'd3, 1'b0, 1'b0, -1);
    run_instr(5'd0, 1'b0, 1'b0, -1);
    run_instr(5'd19, 1'b0, 1'b0, -1);
    run_instr(5'd19, 1'b1, 1'b0, -1);
    run_instr(5'd16, 1'b0, 1'b0, -1);
    run_instr(5'd2, 1'b0, 1'b1, -1);
    halt_reset();
    run_instr(5'd27, 1'b0, 1'b0, -1);
    halt_reset();
    run_instr(5'd0, 1'b0, 1'b0, 6);
    do_reset(3);
    repeat (150) begin
      o = 5'($urandom);
      s = $urandom_range(0, 15) == 0;
      run_instr(o, 1'($urandom), s, -1);
      if (s || o == 5'd27) halt_reset();
    end
    @(posedge Clock);
    @(negedge Clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
